// File: rtl/output_layer_collector.sv
// output_layer_collector
// Serial-to-parallel front end for the argmax stage. Collects N_OUT signed
// neuron values one per handshake into a vector, presents it to select_max
// with out_enable, captures the winning digit on sel_done and re-arms after a
// one-cycle gap so select_max can re-initialise.
//
// Optional feature: define OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN to add a PRESENT
// watchdog. Without it, PRESENT waits for sel_done indefinitely and
// err_timeout is tied low.
//
// Handshake: a value transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is a register that depends on FSM state
// only, never combinationally on in_valid. in_valid/in_data/in_last are
// expected to be held by the source until the transfer happens.

module output_layer_collector #(
    parameter int N_OUT   = 10,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data [0:N_OUT-1],
    output logic                     out_enable,
    input  logic                     sel_done,
    input  logic [7:0]               sel_digit,
    output logic                     result_valid,
    output logic [7:0]               result_digit,
    output logic                     busy,
    output logic                     err_len,
    output logic                     err_timeout,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    // Index of the final vector entry; wr_idx is 8 bits since N_OUT <= 255.
    localparam logic [7:0] LAST_IDX = 8'(N_OUT - 1);

    state_t     state;
    logic [7:0] wr_idx;

    logic accept;
    logic full_beat;
    logic early_last;

`ifdef OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Debug view of the FSM for checkers and waveforms.
    assign dbg_state = state;

    // Beat classification for the current cycle's handshake.
    always_comb begin
        accept     = 1'b0;
        full_beat  = 1'b0;
        early_last = 1'b0;
        if (state == COLLECT && in_valid && in_ready) begin
            accept = 1'b1;
            if (wr_idx == LAST_IDX) begin
                // in_last on the final entry carries no extra meaning.
                full_beat = 1'b1;
            end else if (in_last) begin
                early_last = 1'b1;
            end
        end
    end

    // Vector storage: write the accepted entry, zero-fill the tail on a
    // short frame, otherwise hold (stable throughout PRESENT and GAP).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_OUT; i++) begin
                out_data[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (8'(i) == wr_idx) begin
                    out_data[i] <= in_data;
                end else if (early_last && (8'(i) > wr_idx)) begin
                    out_data[i] <= '0;
                end
            end
        end
    end

    // Control FSM with registered handshake, enable, result and error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= COLLECT;
            wr_idx       <= '0;
            in_ready     <= 1'b0;
            out_enable   <= 1'b0;
            result_valid <= 1'b0;
            result_digit <= '0;
            busy         <= 1'b0;
            err_len      <= 1'b0;
`ifdef OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN
            err_timeout  <= 1'b0;
            tmo_cnt      <= '0;
`endif
        end else begin
            // result_valid is a single-cycle pulse unless re-asserted below.
            result_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    in_ready   <= 1'b1;
                    out_enable <= 1'b0;
`ifdef OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                    if (accept) begin
                        wr_idx <= wr_idx + 8'd1;
                        busy   <= 1'b1;
                        if (full_beat || early_last) begin
                            state      <= PRESENT;
                            in_ready   <= 1'b0;
                            out_enable <= 1'b1;
                        end
                        if (early_last) begin
                            err_len <= 1'b1;
                        end
                    end
                end

                PRESENT: begin
                    in_ready   <= 1'b0;
                    out_enable <= 1'b1;
                    busy       <= 1'b1;
                    // sel_done takes priority over a timeout in the same cycle.
                    if (sel_done) begin
                        result_digit <= sel_digit;
                        result_valid <= 1'b1;
                        out_enable   <= 1'b0;
                        state        <= GAP;
                    end
`ifdef OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LIMIT) begin
                        result_digit <= 8'hFF;
                        result_valid <= 1'b1;
                        err_timeout  <= 1'b1;
                        out_enable   <= 1'b0;
                        state        <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                GAP: begin
                    // One cycle with out_enable low so select_max re-arms.
                    in_ready   <= 1'b1;
                    out_enable <= 1'b0;
                    busy       <= 1'b0;
                    wr_idx     <= '0;
                    state      <= COLLECT;
                end

                default: begin
                    in_ready   <= 1'b0;
                    out_enable <= 1'b0;
                    busy       <= 1'b0;
                    wr_idx     <= '0;
                    state      <= COLLECT;
                end
            endcase
        end
    end

`ifndef OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN
    // Without the watchdog there is nothing that can time out.
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_output_layer_collector.sv
// Testbench for output_layer_collector: directed frames with a scoreboard of
// expected vectors and digits, a select_max stand-in, reset and timeout cases.

module tb_output_layer_collector;

  localparam int N_OUT   = 10;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic sel_done = 1'b0;
  logic [7:0] sel_digit = '0;

  logic in_ready;
  logic signed [DATA_W-1:0] out_data [0:N_OUT-1];
  logic out_enable;
  logic result_valid;
  logic [7:0] result_digit;
  logic busy;
  logic err_len;
  logic err_timeout;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  output_layer_collector #(
    .N_OUT(N_OUT),
    .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_enable(out_enable),
    .sel_done(sel_done),
    .sel_digit(sel_digit),
    .result_valid(result_valid),
    .result_digit(result_digit),
    .busy(busy),
    .err_len(err_len),
    .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int acc_base = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [7:0] dig_q[$];
  logic signed [DATA_W-1:0] fv [N_OUT];
  logic [DATA_W-1:0] cur_vec [N_OUT];

  // Count transfers and result pulses as the DUT sees them at the edge.
  always @(posedge clk) begin
    if (in_valid && in_ready) accepts++;
    if (result_valid) pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag);
    logic [DATA_W-1:0] od;
    for (int i = 0; i < N_OUT; i++) begin
      od = out_data[i];
      check($sformatf("%s[%0d]", tag, i), {16'b0, od}, {16'b0, cur_vec[i]});
    end
  endtask

  function automatic logic [7:0] argmax_model(input int len);
    int best;
    best = 0;
    for (int i = 1; i < len; i++) begin
      if (fv[i] > fv[best]) best = i;
    end
    return 8'(best);
  endfunction

  task automatic send_frame(input int len, input bit gaps);
    int sent;
    int guard;
    sent = 0;
    guard = 0;
    acc_base = accepts;
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(i < len ? fv[i] : '0);
    while (sent < len && guard < 500) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data = DATA_W'($urandom_range(0, 65535));
      end else begin
        in_valid = 1'b1;
        in_data = fv[sent];
        in_last = (sent == len - 1);
      end
      if (in_valid && in_ready) sent++;
    end
    check("send_budget", sent, len);
  endtask

  // One cycle after the final accept: vector presented, input closed.
  task automatic present_check(input bit hold);
    @(negedge clk);
    if (!hold) begin
      in_valid = 1'b0;
      in_last = 1'b0;
    end
    check("oe_latency", {31'b0, out_enable}, 32'd1);
    check("ready_in_present", {31'b0, in_ready}, 32'd0);
    check("busy_in_present", {31'b0, busy}, 32'd1);
    for (int i = 0; i < N_OUT; i++) cur_vec[i] = exp_q.pop_front();
    check_vec("out_data");
  endtask

  // select_max stand-in: answer after lat cycles, then check result and gap.
  task automatic finish_frame(input logic [7:0] dig, input int lat, input int len);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      in_data = DATA_W'($urandom_range(0, 65535));
      check("oe_hold", {31'b0, out_enable}, 32'd1);
      check("rv_idle", {31'b0, result_valid}, 32'd0);
      check_vec("held");
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    sel_done = 1'b1;
    sel_digit = dig;
    dig_q.push_back(dig);
    exp_pulses++;
    @(negedge clk);
    sel_done = 1'b0;
    sel_digit = 8'($urandom_range(0, 255));
    check("result_valid", {31'b0, result_valid}, 32'd1);
    check("result_digit", {24'b0, result_digit}, {24'b0, dig_q.pop_front()});
    check("oe_drop", {31'b0, out_enable}, 32'd0);
    check("ready_gap", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("rv_one_cycle", {31'b0, result_valid}, 32'd0);
    check("oe_after_gap", {31'b0, out_enable}, 32'd0);
    check("ready_rearm", {31'b0, in_ready}, 32'd1);
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("accept_count", accepts - acc_base, len);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] od;
    // reset state
    #12;
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_oe", {31'b0, out_enable}, 32'd0);
    check("rst_rv", {31'b0, result_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err_len", {31'b0, err_len}, 32'd0);
    check("rst_err_tmo", {31'b0, err_timeout}, 32'd0);
    check("rst_digit", {24'b0, result_digit}, 32'd0);
    for (int i = 0; i < N_OUT; i++) cur_vec[i] = '0;
    check_vec("rst_data");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // nominal frame, in_valid held high
    fv = '{16'sd0, 16'sd0, 16'sd5, 16'sd85, 16'sd0, 16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_frame(N_OUT, 1'b0);
    present_check(1'b0);
    od = out_data[3];
    check("nominal_entry3", {16'b0, od}, 32'd85);
    check("nominal_err_len", {31'b0, err_len}, 32'd0);
    finish_frame(argmax_model(N_OUT), 3, N_OUT);

    // sel_done outside PRESENT is ignored
    @(negedge clk);
    sel_done = 1'b1;
    sel_digit = 8'd9;
    @(negedge clk);
    sel_done = 1'b0;
    check("stray_done_rv", {31'b0, result_valid}, 32'd0);
    check("stray_done_oe", {31'b0, out_enable}, 32'd0);
    check("stray_done_busy", {31'b0, busy}, 32'd0);

    // random gaps, then in_valid held high during PRESENT
    for (int i = 0; i < N_OUT; i++) fv[i] = DATA_W'($urandom_range(0, 65535));
    send_frame(N_OUT, 1'b1);
    present_check(1'b1);
    finish_frame(argmax_model(N_OUT), 5, N_OUT);

    // early in_last after four values
    fv = '{-16'sd3, 16'sd7, 16'sd2, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_frame(4, 1'b0);
    present_check(1'b0);
    check("early_err_len", {31'b0, err_len}, 32'd1);
    finish_frame(argmax_model(4), 1, 4);

    // negative values, bit-exact; err_len stays sticky
    for (int i = 0; i < N_OUT; i++) fv[i] = -16'sd1;
    fv[9] = -16'sd32768;
    send_frame(N_OUT, 1'b0);
    present_check(1'b0);
    od = out_data[0];
    check("neg_entry0", {16'b0, od}, 32'h0000FFFF);
    od = out_data[9];
    check("neg_entry9", {16'b0, od}, 32'h00008000);
    check("sticky_err_len", {31'b0, err_len}, 32'd1);
    finish_frame(argmax_model(N_OUT), 2, N_OUT);

    // reset while presenting
    for (int i = 0; i < N_OUT; i++) fv[i] = DATA_W'($urandom_range(1, 65535));
    send_frame(N_OUT, 1'b0);
    present_check(1'b0);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_oe", {31'b0, out_enable}, 32'd0);
    check("rst_mid_err_len", {31'b0, err_len}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < N_OUT; i++) cur_vec[i] = '0;
    check_vec("rst_mid_data");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N_OUT; i++) fv[i] = DATA_W'($urandom_range(0, 65535));
    send_frame(N_OUT, 1'b1);
    present_check(1'b0);
    finish_frame(argmax_model(N_OUT), 2, N_OUT);

    // PRESENT without sel_done
    for (int i = 0; i < N_OUT; i++) fv[i] = DATA_W'($urandom_range(0, 65535));
    send_frame(N_OUT, 1'b0);
    present_check(1'b0);
`ifdef OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      check($sformatf("tmo_wait_%0d", k), {31'b0, result_valid}, 32'd0);
    end
    exp_pulses++;
    @(negedge clk);
    check("tmo_rv", {31'b0, result_valid}, 32'd1);
    check("tmo_digit", {24'b0, result_digit}, 32'h000000FF);
    check("tmo_err", {31'b0, err_timeout}, 32'd1);
    check("tmo_oe", {31'b0, out_enable}, 32'd0);
    @(negedge clk);
    check("tmo_rearm", {31'b0, in_ready}, 32'd1);
    check("tmo_rv_drop", {31'b0, result_valid}, 32'd0);
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("no_tmo_oe_%0d", k), {31'b0, out_enable}, 32'd1);
      check($sformatf("no_tmo_rv_%0d", k), {31'b0, result_valid}, 32'd0);
    end
    check("no_tmo_err", {31'b0, err_timeout}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("recover_ready", {31'b0, in_ready}, 32'd1);
`endif

    // final scoreboard reconciliation
    @(negedge clk);
    check("pulse_count", pulses, exp_pulses);
    check("exp_q_empty", exp_q.size(), 0);
    check("dig_q_empty", dig_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_layer_collector.md
# output_layer_collector

Serial-to-parallel front end for the argmax stage. Accepts the output-layer neuron values one per handshake, assembles them into a 10-entry signed vector, and presents that vector with an enable to `select_max`. It then waits for `select_max` to report completion, captures the winning index, and re-arms for the next frame. It sits between the last neuron layer and `select_max`, and drives the `in_data`/`enable` side of that interface.

## Interface
- `N_OUT`, 10: number of output neurons (vector length); at most 255.
- `DATA_W`, 16: signed neuron value width.
- `TIMEOUT`, 1024: max cycles to wait for `sel_done`; used only with the timeout feature.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  neuron value valid.
- `in_data`  in  DATA_W signed  neuron value.
- `in_last`  in  1  marks the final value of a frame.
- `in_ready`  out  1  collector can accept a value.
- `out_data`  out  [0:N_OUT-1] x DATA_W signed  assembled vector, to `select_max.in_data`.
- `out_enable`  out  1  to `select_max.enable`.
- `sel_done`  in  1  from `select_max.layer_done`.
- `sel_digit`  in  8  from `select_max.digit`.
- `result_valid`  out  1  one-cycle pulse; `result_digit` is valid.
- `result_digit`  out  8  captured argmax index.
- `busy`  out  1  high in every state except COLLECT with `wr_idx`=0.
- `err_len`  out  1  sticky; frame ended early via `in_last`.
- `err_timeout`  out  1  sticky; `sel_done` not seen within `TIMEOUT` cycles.

## Operation
- **States:** COLLECT, PRESENT, GAP.
- **Reset** (async, `reset`=0): state COLLECT, `wr_idx`=0, all `out_data` entries 0. `in_ready`, `out_enable`, `result_valid`, `busy`, `err_len` and `err_timeout` all 0. `result_digit`=0.
- **COLLECT:**
  - `in_ready`=1.
  - On each accept (`in_valid`&`in_ready`): `out_data[wr_idx]` <= `in_data`, then `wr_idx`++.
  - Accept with `wr_idx`=N_OUT-1: go to PRESENT. `in_last` is ignored on this beat.
  - Accept with `in_last`=1 and `wr_idx`<N_OUT-1: entries `wr_idx+1`..N_OUT-1 are written 0 in the same cycle, `err_len` is set, and the state goes to PRESENT.
- **PRESENT:**
  - `in_ready`=0 and `out_enable`=1.
  - `out_data` is held stable for the whole state.
  - On `sel_done`=1: `result_digit` <= `sel_digit`, `result_valid` pulses for 1 cycle, then go to GAP.
- **GAP:**
  - `out_enable`=0 and `in_ready`=0 for exactly 1 cycle. This lets `select_max` re-initialise.
  - `wr_idx` <= 0, then go to COLLECT.
  - `out_data` keeps its last values; the next frame overwrites them entry by entry.
- `sel_done` seen outside PRESENT is ignored.
- No arithmetic on data; values pass through bit-exact, sign preserved.

## Timing
- Latency, last accept to `out_enable`=1: 1 cycle (the registered state change).
- Latency, `sel_done` sampled high to `result_valid`: 1 cycle. `out_enable` drops on the same edge.
- Minimum `out_enable`-low gap between frames: 1 cycle (GAP).
- Maximum throughput: N_OUT + 1 + (select_max latency) + 1 cycles per frame.
- `in_ready` is a registered function of state only. It never depends combinationally on `in_valid`.
- Reset asserted mid-frame or mid-PRESENT: everything clears immediately, `out_enable` drops asynchronously, and no `result_valid` is issued.
- Sticky errors clear only on reset.

## Configuration
- Macro: `OUTPUT_LAYER_COLLECTOR_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter runs in PRESENT.
  - Reaching `TIMEOUT` without `sel_done` sets `err_timeout`, sets `result_digit`=8'hFF, pulses `result_valid`, and goes to GAP.
  - `sel_done` arriving in the same cycle as the counter reaching `TIMEOUT` wins, and the timeout does not fire.
- **Not defined:** there is no counter. PRESENT waits indefinitely and `err_timeout` is tied to 0.

## Test plan
- **Nominal frame:** stream {0,0,5,85,0,10,0,0,0,0} with `in_valid` held high. Expect `out_enable`=1 one cycle after the 10th accept and `out_data[3]`=85. The bench model returns `sel_digit`=3 with `sel_done`. Expect `result_digit`=3, `result_valid` high for exactly 1 cycle, then `out_enable`=0 for 1 cycle, then `in_ready`=1.
- **Gaps and backpressure:** `in_valid` toggling randomly, plus `in_valid` held high while in PRESENT. Expect exactly 10 accepts per frame, no accept while `in_ready`=0, and `out_data` unchanged during PRESENT.
- **Early `in_last`:** send 4 values {-3,7,2,1} with `in_last` on the 4th. Expect `out_data`={-3,7,2,1,0,0,0,0,0,0}, `err_len`=1 and `out_enable`=1.
- **Negative values:** frame of all -1 except entry 9 = -32768. Expect `out_data` bit-exact (16'hFFFF, 16'h8000).
- **Reset mid-PRESENT:** assert `reset`=0 while `out_enable`=1. Expect `out_enable`=0 immediately, `out_data` all 0, no `result_valid`, and the next frame collects normally.
- **Timeout** (macro defined, `TIMEOUT`=16): never assert `sel_done`. Expect `result_valid` with `result_digit`=8'hFF and `err_timeout`=1, 17 cycles after PRESENT entry. With the macro undefined, expect `out_enable` held high indefinitely.
